multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-002 Instr SHALL be an input, 32 bits wide; only [31:28] cond, [27:26] op, [25:20] funct and [15:12] Rd are used.
REQ-003 ALUFlags SHALL be an input, 4 bits wide, ordered {N,Z,C,V} from the ALU.
REQ-004 PCWrite, MemWrite, RegWrite and IRWrite SHALL each be an output, 1 bit wide, acting as a write enable.
REQ-005 AdrSrc SHALL be an output, 1 bit wide: 0 selects PC, 1 selects Result.
REQ-006 ALUSrcA SHALL be an output, 1 bit wide: 0 selects A, 1 selects PC.
REQ-007 ALUSrcB SHALL be an output, 2 bits wide: 00 selects register, 01 selects ExtImm, 10 selects constant 4.
REQ-008 ResultSrc SHALL be an output, 2 bits wide: 00 selects ALUOut, 01 selects Data, 10 selects ALUResult.
REQ-009 ImmSrc, RegSrc and ALUControl SHALL each be an output, 2 bits wide; ALUControl encodes 00 ADD, 01 SUB, 10 AND, 11 ORR.

Function
REQ-010 The Moore FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH and UNKNOWN.
REQ-011 State transitions SHALL be:
- FETCH->DECODE.
- DECODE->EXECUTER (op=00, funct[5]=0); EXECUTEI (op=00, funct[5]=1); MEMADR (op=01); BRANCH (op=10); UNKNOWN (op=11).
- MEMADR->MEMRD if funct[0]=1, else MEMWR.
- MEMRD->MEMWB.
- EXECUTER/EXECUTEI->ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN->FETCH.
REQ-012 Each state SHALL drive the following (unlisted signals 0/00):
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- MEMADR: ALUSrcA=0, ALUSrcB=01.
- MEMRD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: ResultSrc=00, AdrSrc=1, MemW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- UNKNOWN: all 0.
REQ-013 When ALUOp=0, ALUControl SHALL be 00 (ADD) and FlagW SHALL be 00.
REQ-014 When ALUOp=1, ALUControl SHALL decode funct[4:1] as 0100->00, 0010->01, 0000->10, 1100->11, and anything else->00.
REQ-015 When ALUOp=1, FlagW[1] SHALL equal funct[0] (S), and FlagW[0] SHALL equal S AND (ADD or SUB).
REQ-016 ImmSrc SHALL equal op; RegSrc[0] SHALL be 1 iff op=10; RegSrc[1] SHALL be 1 iff op=01.
REQ-017 PCS SHALL equal Branch OR (RegW AND Rd=1111).
REQ-018 Condition evaluation SHALL produce CondEx combinationally from cond and the stored Flags:
- EQ/NE: Z.
- CS/CC: C.
- MI/PL: N.
- VS/VC: V.
- HI/LS: C AND NOT Z.
- GE/LT: N==V.
- GT/LE: NOT Z AND N==V.
- AL (1110): 1.
- 1111: 0.
REQ-019 Flags SHALL be updated as follows:
- Flags[3:2] load ALUFlags[3:2] at a clock edge when FlagW[1] AND CondEx.
- Flags[1:0] load ALUFlags[1:0] when FlagW[0] AND CondEx.
REQ-020 CondExDelayed SHALL be a flop that captures CondEx every cycle.
REQ-021 Gated outputs SHALL be:
- RegWrite = RegW AND CondExDelayed.
- MemWrite = MemW AND CondExDelayed.
- PCWrite = (PCS AND CondExDelayed) OR NextPC.
REQ-022 Latency SHALL be 5 cycles for LDR, 4 cycles for STR and data-processing instructions, and 3 cycles for B, always measured from FETCH entry.
REQ-023 A failed condition SHALL still traverse every state, with no register, memory, PC or flag side effect beyond the FETCH increment.
REQ-024 Rd=R15 in ALUWB or MEMWB SHALL assert PCWrite in that cycle when the condition passes.

Reset
REQ-025 While reset is high, MemWrite and RegWrite SHALL be forced to 0; the next state SHALL be FETCH, Flags SHALL be 0000, and CondExDelayed SHALL be 0.
REQ-026 Reset asserted in any state, including MEMWR, SHALL take effect at the next edge with no write issued during the reset cycle; after release, the outputs SHALL equal the FETCH values.

Structure
REQ-027 A shared package SHALL hold the state enum, the ALUControl, ALUSrcB and ResultSrc encodings, and the cond-code constants.
REQ-028 Condition logic (flags register, CondEx, CondExDelayed, write gating) SHALL be a single sub-module named condlogic.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- ADD R1,R2,R3 (0xE0821003): states FETCH, DECODE, EXECUTER, ALUWB -> ALUControl=00 in EXECUTER, RegWrite=1 only in ALUWB.
- LDR R2,[R0,#4] (0xE5902004): 5 states -> AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB.
- STR R2,[R0,#4] (0xE5802004) -> MemWrite=1 only in MEMWR; RegWrite never 1.
- SUBS R0,R0,R0 (0xE0500000) with ALUFlags=0100, then BEQ (0x0A000002) -> Flags=0100 and PCWrite=1 in BRANCH; with Z=0, PCWrite=0 in BRANCH.
- Reset asserted in MEMWR -> MemWrite=0 that cycle; next state FETCH, Flags=0000.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the FSM state enum, the mux/ALU select encodings and the ARM
// condition-code constants used by the controller and its condition logic.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      SRCB_REG  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } srcb_e;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } result_e;

   // Data-processing cmd field (funct[4:1]) values the controller decodes.
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/multicycle_controller_condlogic.sv
// Condition logic for the multicycle controller.
// Keeps the NZCV flags register, evaluates the instruction condition,
// delays that result by one cycle and gates the architectural writes.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   cond_i[3:0]      : instruction condition field
//   alu_flags_i[3:0] : {N,Z,C,V} from the ALU
//   flag_w_i[1:0]    : flag write enables ([1] -> N,Z ; [0] -> C,V)
//   pcs_i, next_pc_i : PC write requests (conditional / unconditional)
//   reg_w_i, mem_w_i : register / memory write requests
//   pc_write_o, reg_write_o, mem_write_o : gated write enables
module condlogic
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic [1:0] flag_w_i,
   input  logic       pcs_i,
   input  logic       next_pc_i,
   input  logic       reg_w_i,
   input  logic       mem_w_i,
   output logic       pc_write_o,
   output logic       reg_write_o,
   output logic       mem_write_o
);

   logic [3:0] flags_q, flags_d;
   logic       cond_ex;
   logic       cond_ex_dly_q;
   logic       n_f, z_f, c_f, v_f;

   assign {n_f, z_f, c_f, v_f} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      unique case (cond_i)
         COND_EQ: cond_ex = z_f;
         COND_NE: cond_ex = ~z_f;
         COND_CS: cond_ex = c_f;
         COND_CC: cond_ex = ~c_f;
         COND_MI: cond_ex = n_f;
         COND_PL: cond_ex = ~n_f;
         COND_VS: cond_ex = v_f;
         COND_VC: cond_ex = ~v_f;
         COND_HI: cond_ex = c_f & ~z_f;
         COND_LS: cond_ex = ~(c_f & ~z_f);
         COND_GE: cond_ex = (n_f == v_f);
         COND_LT: cond_ex = (n_f != v_f);
         COND_GT: cond_ex = ~z_f & (n_f == v_f);
         COND_LE: cond_ex = ~(~z_f & (n_f == v_f));
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end

   always_comb begin
      flags_d = flags_q;
      if (flag_w_i[1] && cond_ex) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w_i[0] && cond_ex) flags_d[1:0] = alu_flags_i[1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q       <= '0;
         cond_ex_dly_q <= 1'b0;
      end else begin
         flags_q       <= flags_d;
         cond_ex_dly_q <= cond_ex;
      end
   end

   // Writes are issued one state after the condition was evaluated, so they
   // use the delayed result; reset masks them in the same cycle.
   assign reg_write_o = reg_w_i & cond_ex_dly_q & ~reset;
   assign mem_write_o = mem_w_i & cond_ex_dly_q & ~reset;
   assign pc_write_o  = (pcs_i & cond_ex_dly_q) | next_pc_i;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller.
// Moore FSM sequencing FETCH/DECODE/execute states, ALU decoder, and the
// condition logic sub-module that gates register, memory and PC writes.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   Instr[31:0]  : instruction (cond, op, funct and Rd fields used)
//   ALUFlags[3:0]: {N,Z,C,V} from the ALU
//   PCWrite, MemWrite, RegWrite, IRWrite : write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc  : datapath mux selects
//   ImmSrc, RegSrc, ALUControl           : decode outputs
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUControl
);

   state_e     state_q, state_d;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cmd;

   logic       next_pc;
   logic       alu_op;
   logic       reg_w;
   logic       mem_w;
   logic       branch;
   logic       pcs;
   logic [1:0] flag_w;
   alu_ctrl_e  alu_ctrl;
   logic       unused_instr_bits;

   assign cond  = Instr[31:28];
   assign op    = Instr[27:26];
   assign funct = Instr[25:20];
   assign rd    = Instr[15:12];
   assign cmd   = funct[4:1];
   assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            unique case (op)
               2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      next_pc   = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      alu_op    = 1'b0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      branch    = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            IRWrite   = 1'b1;
            next_pc   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_EXECUTER: alu_op = 1'b1;
         S_EXECUTEI: begin
            ALUSrcB = SRCB_IMM;
            alu_op  = 1'b1;
         end
         S_ALUWB:  reg_w = 1'b1;
         S_MEMADR: ALUSrcB = SRCB_IMM;
         S_MEMRD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_w     = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            mem_w  = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
            branch    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      alu_ctrl = ALU_ADD;
      flag_w   = '0;
      if (alu_op) begin
         unique case (cmd)
            CMD_ADD: alu_ctrl = ALU_ADD;
            CMD_SUB: alu_ctrl = ALU_SUB;
            CMD_AND: alu_ctrl = ALU_AND;
            CMD_ORR: alu_ctrl = ALU_ORR;
            default: alu_ctrl = ALU_ADD;
         endcase
         // C and V only carry meaning for arithmetic operations.
         flag_w[1] = funct[0];
         flag_w[0] = funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));
      end
   end

   assign ALUControl = alu_ctrl;
   assign ImmSrc     = op;
   assign RegSrc     = {op == 2'b01, op == 2'b10};
   assign pcs        = branch | (reg_w & (rd == 4'b1111));

   condlogic u_condlogic (
      .clk         (clk),
      .reset       (reset),
      .cond_i      (cond),
      .alu_flags_i (ALUFlags),
      .flag_w_i    (flag_w),
      .pcs_i       (pcs),
      .next_pc_i   (next_pc),
      .reg_w_i     (reg_w),
      .mem_w_i     (mem_w),
      .pc_write_o  (PCWrite),
      .reg_write_o (RegWrite),
      .mem_write_o (MemWrite)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl)
   );

   // Phases of an instruction as listed in the state table.
   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3,
                  P_MEMWB = 4, P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7,
                  P_ALUWB = 8, P_BRANCH = 9, P_UNKNOWN = 10;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned icount  = 0;
   logic [3:0]  m_flags;
   logic        m_cde;
   int          plan[$];
   logic [15:0] last_obs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic string pname(input int p);
      case (p)
         P_FETCH:  return "FETCH";
         P_DECODE: return "DECODE";
         P_MEMADR: return "MEMADR";
         P_MEMRD:  return "MEMRD";
         P_MEMWB:  return "MEMWB";
         P_MEMWR:  return "MEMWR";
         P_EXECR:  return "EXECR";
         P_EXECI:  return "EXECI";
         P_ALUWB:  return "ALUWB";
         P_BRANCH: return "BRANCH";
         default:  return "UNKNOWN";
      endcase
   endfunction

   // Condition rule: pairs share a base test, odd codes invert it.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      if (c == 4'd14) return 1'b1;
      if (c == 4'd15) return 1'b0;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return base ^ c[0];
   endfunction

   task automatic build_plan(input logic [31:0] instr);
      plan.delete();
      plan.push_back(P_FETCH);
      plan.push_back(P_DECODE);
      case (instr[27:26])
         2'b00: begin
            plan.push_back(instr[25] ? P_EXECI : P_EXECR);
            plan.push_back(P_ALUWB);
         end
         2'b01: begin
            plan.push_back(P_MEMADR);
            if (instr[20]) begin
               plan.push_back(P_MEMRD);
               plan.push_back(P_MEMWB);
            end else begin
               plan.push_back(P_MEMWR);
            end
         end
         2'b10: plan.push_back(P_BRANCH);
         default: plan.push_back(P_UNKNOWN);
      endcase
   endtask

   // Expected output vector:
   // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,RegSrc,ALUControl}
   function automatic logic [15:0] expect_outs(input int p, input logic [31:0] instr, input logic cde);
      logic nxt = 0, irw = 0, adr = 0, sa = 0, aop = 0, rw = 0, mw = 0, br = 0;
      logic [1:0] sb = 2'b00, rs = 2'b00, ctl = 2'b00;
      logic [3:0] cmd;
      logic pcs;
      logic [1:0] op;
      op  = instr[27:26];
      cmd = instr[24:21];
      case (p)
         P_FETCH:  begin irw = 1; nxt = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
         P_DECODE: begin sa = 1; sb = 2'b10; rs = 2'b10; end
         P_EXECR:  aop = 1;
         P_EXECI:  begin sb = 2'b01; aop = 1; end
         P_ALUWB:  rw = 1;
         P_MEMADR: sb = 2'b01;
         P_MEMRD:  adr = 1;
         P_MEMWB:  begin rs = 2'b01; rw = 1; end
         P_MEMWR:  begin adr = 1; mw = 1; end
         P_BRANCH: begin sb = 2'b01; rs = 2'b10; br = 1; end
         default: ;
      endcase
      if (aop) begin
         if (cmd == 4'b0010) ctl = 2'b01;
         else if (cmd == 4'b0000) ctl = 2'b10;
         else if (cmd == 4'b1100) ctl = 2'b11;
         else ctl = 2'b00;
      end
      pcs = br || (rw && instr[15:12] == 4'hF);
      return {(pcs && cde) || nxt, mw && cde, rw && cde, irw, adr, sa, sb, rs,
              op, {op == 2'b01, op == 2'b10}, ctl};
   endfunction

   // Runs up to max_steps phases of one instruction; entry is just after the
   // edge that puts the controller in FETCH.
   task automatic run_instr(input logic [31:0] instr, input bit rnd_flags,
                            input logic [3:0] aflags, input int max_steps);
      logic [15:0] exp, obs;
      logic ce;
      int p;
      build_plan(instr);
      for (int i = 0; i < plan.size() && i < max_steps; i++) begin
         p = plan[i];
         Instr    = instr;
         ALUFlags = rnd_flags ? 4'($urandom) : aflags;
         @(negedge clk);
         exp = expect_outs(p, instr, m_cde);
         obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSrc, RegSrc, ALUControl};
         check($sformatf("%s_i%0d_%h", pname(p), icount, instr), 32'(obs), 32'(exp));
         last_obs = obs;
         @(posedge clk);
         ce = cond_ok(instr[31:28], m_flags);
         if ((p == P_EXECR || p == P_EXECI) && instr[20] && ce) begin
            m_flags[3:2] = ALUFlags[3:2];
            if (instr[24:21] == 4'b0100 || instr[24:21] == 4'b0010)
               m_flags[1:0] = ALUFlags[1:0];
         end
         m_cde = ce;
         #1;
      end
      check($sformatf("flags_i%0d", icount), 32'(dut.u_condlogic.flags_q), 32'(m_flags));
      icount++;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rd;
      logic [3:0]  cmds [4];
      cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
      op = 2'($urandom_range(0, 3));
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      if (op == 2'b00)
         funct = {1'($urandom), cmds[$urandom_range(0, 3)], 1'($urandom)};
      else
         funct = 6'($urandom);
      return {4'($urandom), op, funct, 4'($urandom), rd, 12'($urandom)};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      Instr    = '0;
      ALUFlags = '0;
      m_flags  = '0;
      m_cde    = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_flags", 32'(dut.u_condlogic.flags_q), 32'h0);

      // Directed instructions
      run_instr(32'hE0821003, 0, 4'h0, 10);   // ADD R1,R2,R3
      run_instr(32'hE5902004, 0, 4'h0, 10);   // LDR R2,[R0,#4]
      run_instr(32'hE5802004, 0, 4'h0, 10);   // STR R2,[R0,#4]
      run_instr(32'hE0500000, 0, 4'h4, 10);   // SUBS R0,R0,R0, Z set
      check("subs_flags", 32'(dut.u_condlogic.flags_q), 32'h4);
      run_instr(32'h0A000002, 0, 4'h0, 10);   // BEQ taken
      check("beq_taken_pcwrite", 32'(last_obs[15]), 32'h1);
      run_instr(32'hE0500000, 0, 4'h0, 10);   // SUBS, Z clear
      run_instr(32'h0A000002, 0, 4'h0, 10);   // BEQ not taken
      check("beq_not_taken_pcwrite", 32'(last_obs[15]), 32'h0);

      // Reset while in MEMWR of a store
      run_instr(32'hE5802004, 0, 4'h0, 3);
      Instr = 32'hE5802004;
      reset = 1'b1;
      @(negedge clk);
      check("rst_memwr_memwrite", 32'(MemWrite), 32'h0);
      check("rst_memwr_regwrite", 32'(RegWrite), 32'h0);
      @(posedge clk);
      m_flags = '0;
      m_cde   = 1'b0;
      #1 reset = 1'b0;
      check("rst_memwr_flags", 32'(dut.u_condlogic.flags_q), 32'h0);

      // Randomized instruction stream
      for (int k = 0; k < 250; k++) run_instr(rand_instr(), 1, 4'h0, 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
